// File: rtl/gelato_types.sv
// rtl/gelato_types.sv - shared types for the gelato block dispatcher
//
// Purpose: common type definitions for the kernel block dispatcher and its
//          round-robin SM picker.
//   addr_t           32-bit kernel entry address
//   int3_t           packed (x, y, z) triple, each 32-bit unsigned
//   dispatch_state_t dispatcher FSM states
package gelato_types;

   typedef logic [31:0] addr_t;

   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] z;
   } int3_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DISPATCH = 2'd1,
      DRAIN    = 2'd2,
      DONE     = 2'd3
   } dispatch_state_t;

endpackage

// File: rtl/gelato_rr_arbiter.sv
// rtl/gelato_rr_arbiter.sv - combinational round-robin picker
//
// Purpose: pick the first requester at or after ptr, wrapping modulo NUM_SM.
// Ports:
//   req      in   NUM_SM     request vector (one bit per SM)
//   ptr      in   SM_IDX_W   starting position of the search (< NUM_SM)
//   gnt      out  NUM_SM     one-hot grant, zero when nothing requests
//   gnt_idx  out  SM_IDX_W   index of the granted requester
//   gnt_any  out  1          a grant was made
module gelato_rr_arbiter #(
   parameter int NUM_SM   = 4,
   parameter int SM_IDX_W = (NUM_SM > 1) ? $clog2(NUM_SM) : 1
) (
   input  logic [NUM_SM-1:0]   req,
   input  logic [SM_IDX_W-1:0] ptr,
   output logic [NUM_SM-1:0]   gnt,
   output logic [SM_IDX_W-1:0] gnt_idx,
   output logic                gnt_any
);

   int cand;

   // Walk offsets 0..NUM_SM-1 from ptr; the first requester seen wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = 0;
      for (int k = 0; k < NUM_SM; k++) begin
         cand = (int'(ptr) + k) % NUM_SM;
         if (!gnt_any && req[cand]) begin
            gnt_any   = 1'b1;
            gnt[cand] = 1'b1;
            gnt_idx   = SM_IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/gelato_block_dispatcher.sv
// rtl/gelato_block_dispatcher.sv - kernel block scheduler to per-SM controllers
//
// Purpose: accept one kernel launch, walk blockIdx over the grid (x fastest,
//          then y, then z), hand each block to a free SM as a one-cycle init
//          pulse, and pulse kernel_done once every block has retired.
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   launch_valid/ready  launch handshake (ready only in IDLE)
//   launch_pc/grid_dim/block_dim   kernel launch parameters
//   sm_valid            one-hot init pulse to the target SM
//   sm_pc/grid_dim/block_dim/block_idx   registered broadcast fields
//   sm_done             per-SM retire pulse
//   busy                high whenever not IDLE
//   kernel_done         one-cycle completion pulse
module gelato_block_dispatcher
   import gelato_types::*;
#(
   parameter int NUM_SM   = 4,
   parameter int SM_IDX_W = (NUM_SM > 1) ? $clog2(NUM_SM) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              launch_valid,
   output logic              launch_ready,
   input  addr_t             launch_pc,
   input  int3_t             launch_grid_dim,
   input  int3_t             launch_block_dim,
   output logic [NUM_SM-1:0] sm_valid,
   output addr_t             sm_pc,
   output int3_t             sm_grid_dim,
   output int3_t             sm_block_dim,
   output int3_t             sm_block_idx,
   input  logic [NUM_SM-1:0] sm_done,
   output logic              busy,
   output logic              kernel_done
);

   dispatch_state_t     state_q, state_d;
   logic [NUM_SM-1:0]   occ_q, occ_d;
   logic [SM_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   int3_t               idx_q, idx_d;
   addr_t               pc_q, pc_d;
   int3_t               grid_q, grid_d;
   int3_t               blk_q, blk_d;
   logic [NUM_SM-1:0]   sm_valid_q, sm_valid_d;
   addr_t               sm_pc_q, sm_pc_d;
   int3_t               sm_grid_q, sm_grid_d;
   int3_t               sm_blk_q, sm_blk_d;
   int3_t               sm_idx_q, sm_idx_d;

   logic [NUM_SM-1:0]   gnt;
   logic [SM_IDX_W-1:0] gnt_idx;
   logic                gnt_any;

   logic                x_end, y_end, z_end;
   int3_t               idx_next;

   // Free mask comes from registered occupancy, so an SM retiring this
   // cycle is only eligible from the next one.
   gelato_rr_arbiter #(
      .NUM_SM   (NUM_SM),
      .SM_IDX_W (SM_IDX_W)
   ) u_rr_arbiter (
      .req     (~occ_q),
      .ptr     (rr_ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   // Per-component end tests avoid ever forming the grid product.
   always_comb begin
      x_end    = (idx_q.x == grid_q.x - 32'd1);
      y_end    = (idx_q.y == grid_q.y - 32'd1);
      z_end    = (idx_q.z == grid_q.z - 32'd1);
      idx_next = idx_q;
      if (x_end) begin
         idx_next.x = '0;
         if (y_end) begin
            idx_next.y = '0;
            idx_next.z = idx_q.z + 32'd1;
         end else begin
            idx_next.y = idx_q.y + 32'd1;
         end
      end else begin
         idx_next.x = idx_q.x + 32'd1;
      end
   end

   always_comb begin
      state_d    = state_q;
      occ_d      = occ_q & ~sm_done;
      rr_ptr_d   = rr_ptr_q;
      idx_d      = idx_q;
      pc_d       = pc_q;
      grid_d     = grid_q;
      blk_d      = blk_q;
      sm_valid_d = '0;
      sm_pc_d    = sm_pc_q;
      sm_grid_d  = sm_grid_q;
      sm_blk_d   = sm_blk_q;
      sm_idx_d   = sm_idx_q;

      case (state_q)
         IDLE: begin
            if (launch_valid) begin
               pc_d   = launch_pc;
               grid_d = launch_grid_dim;
               blk_d  = launch_block_dim;
               idx_d  = '0;
               if ((launch_grid_dim.x == '0) || (launch_grid_dim.y == '0) ||
                   (launch_grid_dim.z == '0)) begin
                  state_d = DONE;
               end else begin
                  state_d = DISPATCH;
               end
            end
         end
         DISPATCH: begin
            if (gnt_any) begin
               // Grant is OR-ed after the done clear so it wins a collision.
               occ_d      = occ_d | gnt;
               sm_valid_d = gnt;
               sm_pc_d    = pc_q;
               sm_grid_d  = grid_q;
               sm_blk_d   = blk_q;
               sm_idx_d   = idx_q;
               rr_ptr_d   = (gnt_idx == SM_IDX_W'(NUM_SM - 1)) ? '0
                                                               : gnt_idx + SM_IDX_W'(1);
               idx_d      = idx_next;
               if (x_end && y_end && z_end) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (occ_d == '0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         occ_q      <= '0;
         rr_ptr_q   <= '0;
         idx_q      <= '0;
         pc_q       <= '0;
         grid_q     <= '0;
         blk_q      <= '0;
         sm_valid_q <= '0;
         sm_pc_q    <= '0;
         sm_grid_q  <= '0;
         sm_blk_q   <= '0;
         sm_idx_q   <= '0;
      end else begin
         state_q    <= state_d;
         occ_q      <= occ_d;
         rr_ptr_q   <= rr_ptr_d;
         idx_q      <= idx_d;
         pc_q       <= pc_d;
         grid_q     <= grid_d;
         blk_q      <= blk_d;
         sm_valid_q <= sm_valid_d;
         sm_pc_q    <= sm_pc_d;
         sm_grid_q  <= sm_grid_d;
         sm_blk_q   <= sm_blk_d;
         sm_idx_q   <= sm_idx_d;
      end
   end

   assign sm_valid     = sm_valid_q;
   assign sm_pc        = sm_pc_q;
   assign sm_grid_dim  = sm_grid_q;
   assign sm_block_dim = sm_blk_q;
   assign sm_block_idx = sm_idx_q;
   assign launch_ready = (state_q == IDLE);
   assign busy         = (state_q != IDLE);
   assign kernel_done  = (state_q == DONE);

endmodule

// File: tb/tb_gelato_block_dispatcher.sv
// tb/tb_gelato_block_dispatcher.sv - directed self-checking bench for gelato_block_dispatcher
module tb_gelato_block_dispatcher;
   import gelato_types::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        launch_valid;
   logic        launch_ready;
   addr_t       launch_pc;
   int3_t       launch_grid_dim;
   int3_t       launch_block_dim;
   logic [3:0]  sm_valid;
   addr_t       sm_pc;
   int3_t       sm_grid_dim;
   int3_t       sm_block_dim;
   int3_t       sm_block_idx;
   logic [3:0]  sm_done;
   logic        busy;
   logic        kernel_done;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   gelato_block_dispatcher #(.NUM_SM(4)) dut (
      .clk              (clk),
      .rst              (rst),
      .launch_valid     (launch_valid),
      .launch_ready     (launch_ready),
      .launch_pc        (launch_pc),
      .launch_grid_dim  (launch_grid_dim),
      .launch_block_dim (launch_block_dim),
      .sm_valid         (sm_valid),
      .sm_pc            (sm_pc),
      .sm_grid_dim      (sm_grid_dim),
      .sm_block_dim     (sm_block_dim),
      .sm_block_idx     (sm_block_idx),
      .sm_done          (sm_done),
      .busy             (busy),
      .kernel_done      (kernel_done)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int3_t v3(input int unsigned x, input int unsigned y, input int unsigned z);
      int3_t r;
      r.x = x;
      r.y = y;
      r.z = z;
      return r;
   endfunction

   task automatic launch(input addr_t pc, input int3_t g, input int3_t b);
      launch_valid     = 1'b1;
      launch_pc        = pc;
      launch_grid_dim  = g;
      launch_block_dim = b;
   endtask

   task automatic do_reset;
      rst          = 1'b1;
      launch_valid = 1'b0;
      sm_done      = '0;
      tick;
      tick;
      rst = 1'b0;
   endtask

   initial begin
      int n_issued;
      int n_kdone;
      int last_done;
      int kdone_cyc;
      int done_at[4];

      rst              = 1'b1;
      launch_valid     = 1'b0;
      launch_pc        = '0;
      launch_grid_dim  = '0;
      launch_block_dim = '0;
      sm_done          = '0;
      tick;
      tick;
      rst = 1'b0;
      tick;

      // Reset state
      check("rst_ready", launch_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_kdone", kernel_done, 1'b0);
      check("rst_valid", sm_valid, 4'b0000);
      check("rst_pc", sm_pc, 32'h0);
      check("rst_idx", sm_block_idx, v3(0, 0, 0));
      check("rst_grid", sm_grid_dim, v3(0, 0, 0));
      check("rst_blk", sm_block_dim, v3(0, 0, 0));

      // Grid (2,1,1): two back-to-back grants, drain, done
      launch(32'h100, v3(2, 1, 1), v3(32, 1, 1));
      check("s1_ready_t", launch_ready, 1'b1);
      tick;
      launch_valid = 1'b0;
      check("s1_busy_t1", busy, 1'b1);
      check("s1_valid_t1", sm_valid, 4'b0000);
      tick;
      check("s1_valid_t2", sm_valid, 4'b0001);
      check("s1_idx_t2", sm_block_idx, v3(0, 0, 0));
      check("s1_pc_t2", sm_pc, 32'h100);
      check("s1_grid_t2", sm_grid_dim, v3(2, 1, 1));
      check("s1_blk_t2", sm_block_dim, v3(32, 1, 1));
      tick;
      check("s1_valid_t3", sm_valid, 4'b0010);
      check("s1_idx_t3", sm_block_idx, v3(1, 0, 0));
      tick;
      check("s1_valid_t4", sm_valid, 4'b0000);
      check("s1_drain", dut.state_q, DRAIN);
      check("s1_kdone_t4", kernel_done, 1'b0);
      sm_done = 4'b0011;
      tick;
      sm_done = 4'b0000;
      check("s1_kdone_t5", kernel_done, 1'b1);
      tick;
      check("s1_kdone_t6", kernel_done, 1'b0);
      check("s1_ready_t6", launch_ready, 1'b1);

      // Grid (3,2,2), each SM retires 4 cycles after its init pulse
      do_reset;
      launch(32'h400, v3(3, 2, 2), v3(64, 1, 1));
      tick;
      launch_valid = 1'b0;
      n_issued  = 0;
      n_kdone   = 0;
      last_done = -1;
      kdone_cyc = -1;
      for (int s = 0; s < 4; s++) done_at[s] = -1;
      for (int cyc = 0; cyc < 200 && n_kdone == 0; cyc++) begin
         logic [3:0] d;
         d = '0;
         tick;
         if (sm_valid != 4'b0000) begin
            check("s2_valid", sm_valid, 4'b0001 << (n_issued % 4));
            check("s2_idx", sm_block_idx,
                  v3(n_issued % 3, (n_issued / 3) % 2, n_issued / 6));
            for (int s = 0; s < 4; s++) if (sm_valid[s]) done_at[s] = cyc + 4;
            n_issued++;
         end
         if (kernel_done) begin
            n_kdone++;
            kdone_cyc = cyc;
         end
         for (int s = 0; s < 4; s++) begin
            if (done_at[s] == cyc) begin
               d[s]       = 1'b1;
               done_at[s] = -1;
               last_done  = cyc;
            end
         end
         sm_done = d;
      end
      sm_done = '0;
      tick;
      if (kernel_done) n_kdone++;
      check("s2_issued", n_issued, 12);
      check("s2_kdone_cnt", n_kdone, 1);
      check("s2_kdone_cyc", kdone_cyc, last_done + 1);

      // Grid (6,1,1): stall with all SMs busy, launch held during dispatch
      do_reset;
      launch(32'h500, v3(6, 1, 1), v3(16, 1, 1));
      tick;
      launch_pc = 32'h5ff;
      check("s3_ready_disp", launch_ready, 1'b0);
      for (int k = 0; k < 4; k++) begin
         tick;
         check("s3_valid_fill", sm_valid, 4'b0001 << k);
         check("s3_idx_fill", sm_block_idx, v3(k, 0, 0));
      end
      tick;
      check("s3_stall_a", sm_valid, 4'b0000);
      tick;
      check("s3_stall_b", sm_valid, 4'b0000);
      check("s3_idx_held", dut.idx_q, v3(4, 0, 0));
      check("s3_ready_held", launch_ready, 1'b0);
      sm_done = 4'b0010;
      tick;
      sm_done = 4'b0000;
      check("s3_no_early", sm_valid, 4'b0000);
      tick;
      check("s3_regrant", sm_valid, 4'b0010);
      check("s3_regrant_idx", sm_block_idx, v3(4, 0, 0));
      check("s3_pc_kept", sm_pc, 32'h500);
      sm_done = 4'b1101;
      tick;
      sm_done = 4'b0000;
      check("s3_gap", sm_valid, 4'b0000);
      tick;
      check("s3_last", sm_valid, 4'b0100);
      check("s3_last_idx", sm_block_idx, v3(5, 0, 0));
      sm_done = 4'b1000;
      tick;
      sm_done = 4'b0000;
      check("s3_stray_occ", dut.occ_q, 4'b0110);
      check("s3_stray_kd", kernel_done, 1'b0);
      sm_done = 4'b0110;
      tick;
      sm_done = 4'b0000;
      check("s3_kdone", kernel_done, 1'b1);
      check("s3_ready_done", launch_ready, 1'b0);
      launch(32'h200, v3(1, 1, 1), v3(8, 1, 1));
      tick;
      check("s3_idle_ready", launch_ready, 1'b1);
      check("s3_idle_kd", kernel_done, 1'b0);
      tick;
      launch_valid = 1'b0;
      check("s3_relaunch_busy", busy, 1'b1);
      tick;
      check("s3_relaunch_sm3", sm_valid, 4'b1000);
      check("s3_relaunch_pc", sm_pc, 32'h200);
      sm_done = 4'b1000;
      tick;
      sm_done = 4'b0000;
      check("s3_relaunch_kd", kernel_done, 1'b1);

      // Empty grid (0,4,4)
      do_reset;
      launch(32'h600, v3(0, 4, 4), v3(1, 1, 1));
      tick;
      launch_valid = 1'b0;
      check("s4_kdone", kernel_done, 1'b1);
      check("s4_valid", sm_valid, 4'b0000);
      tick;
      check("s4_ready", launch_ready, 1'b1);
      check("s4_kdone_off", kernel_done, 1'b0);
      check("s4_valid2", sm_valid, 4'b0000);

      // Asynchronous reset in the middle of dispatch
      do_reset;
      launch(32'h700, v3(8, 8, 1), v3(4, 1, 1));
      tick;
      launch_valid = 1'b0;
      tick;
      tick;
      check("s5_pre_valid", sm_valid, 4'b0010);
      #2;
      rst = 1'b1;
      #1;
      check("s5_valid", sm_valid, 4'b0000);
      check("s5_pc", sm_pc, 32'h0);
      check("s5_idx", sm_block_idx, v3(0, 0, 0));
      check("s5_busy", busy, 1'b0);
      check("s5_kdone", kernel_done, 1'b0);
      check("s5_ready", launch_ready, 1'b1);
      tick;
      rst = 1'b0;
      launch(32'h300, v3(2, 1, 1), v3(1, 1, 1));
      tick;
      launch_valid = 1'b0;
      tick;
      check("s5_new_valid", sm_valid, 4'b0001);
      check("s5_new_idx", sm_block_idx, v3(0, 0, 0));
      check("s5_new_pc", sm_pc, 32'h300);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
